// File: rtl/montgomery_precompute.sv
// montgomery_precompute: bit-serial R mod m / R^2 mod m setup for the Montgomery exponentiator
// Ports: clk, reset (async, active-high), start/m (request + modulus, sampled in IDLE),
// busy, done (one-cycle pulse), err (m even), r_mod_m, r2_mod_m, m_prime (-m^-1 mod R).
// Optional: define MONTGOMERY_PRECOMPUTE_MPRIME_EN to compute m_prime; otherwise it is 0.
module montgomery_precompute #(
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(2*WORD_WIDTH)+1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] m,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WORD_WIDTH-1:0] r_mod_m,
  output logic [WORD_WIDTH-1:0] r2_mod_m,
  output logic [WORD_WIDTH-1:0] m_prime
);
  typedef enum logic [1:0] {IDLE, DBL, DONE} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST_R = CNT_WIDTH'(WORD_WIDTH-1);
  localparam logic [CNT_WIDTH-1:0] LAST   = CNT_WIDTH'(2*WORD_WIDTH-1);
  state_t                r_state, w_next;
  logic [WORD_WIDTH-1:0] r_m, r_rs;
  logic [WORD_WIDTH:0]   r_acc, w_t, w_acc;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_err, w_acc_en, w_fin;
  // acc < m always, so doubling fits in WORD_WIDTH+1 bits and one subtract suffices
  always_comb begin
    w_t      = r_acc << 1;
    w_acc    = (w_t >= {1'b0, r_m}) ? w_t - {1'b0, r_m} : w_t;
    w_acc_en = r_state == IDLE && start;
    w_fin    = r_state == DBL && r_cnt == LAST;
    w_next   = r_state == IDLE ? (start ? DBL : IDLE) : r_state == DBL ? (w_fin ? DONE : DBL) : IDLE;
  end
  // An even modulus is parked on the last doubling step with acc=0, so it finishes
  // one cycle after acceptance through the same result path with zero results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      r_mod_m  <= '0;
      r2_mod_m <= '0;
      r_m      <= '0;
      r_rs     <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      busy    <= w_next == DBL;
      done    <= w_next == DONE;
      if (w_acc_en) begin
        r_m   <= m;
        r_err <= ~m[0];
        r_acc <= (WORD_WIDTH+1)'(m[0] && m != WORD_WIDTH'(1));
        r_cnt <= m[0] ? '0 : LAST;
        r_rs  <= '0;
      end else if (r_state == DBL) begin
        r_acc <= w_acc;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LAST_R) r_rs <= w_acc[WORD_WIDTH-1:0];
        if (w_fin) begin
          r_mod_m  <= r_rs;
          r2_mod_m <= w_acc[WORD_WIDTH-1:0];
          err      <= r_err;
        end
      end
    end
  end
`ifdef MONTGOMERY_PRECOMPUTE_MPRIME_EN
  logic [WORD_WIDTH:0]   r_h;
  logic [WORD_WIDTH-1:0] r_mp;
  // Hensel lifting: h stays <= m, so h + m fits in WORD_WIDTH+1 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h     <= '0;
      r_mp    <= '0;
      m_prime <= '0;
    end else if (w_acc_en) begin
      r_h  <= (WORD_WIDTH+1)'(1);
      r_mp <= '0;
    end else if (r_state == DBL) begin
      if (r_cnt < CNT_WIDTH'(WORD_WIDTH)) begin
        r_h  <= r_h[0] ? (r_h + {1'b0, r_m}) >> 1 : r_h >> 1;
        r_mp <= r_mp | (WORD_WIDTH'(r_h[0]) << r_cnt);
      end
      if (w_fin) m_prime <= r_mp;
    end
  end
`else
  assign m_prime = '0;
`endif
endmodule

// File: tb/tb_montgomery_precompute.sv
// tb_montgomery_precompute: randomized and directed checks of montgomery_precompute against an arithmetic model
module tb_montgomery_precompute;
`ifdef MONTGOMERY_PRECOMPUTE_MPRIME_EN
  localparam bit MP = 1'b1;
`else
  localparam bit MP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic s8 = 1'b0, s32 = 1'b0;
  logic [7:0] m8 = '0, r8, r28, mp8;
  logic [31:0] m32 = '0, r32, r232, mp32;
  logic busy8, done8, err8, busy32, done32, err32;
  int np = 0, nt = 0;
  montgomery_precompute #(.WORD_WIDTH(8)) d8 (
    .clk(clk), .reset(reset), .start(s8), .m(m8), .busy(busy8), .done(done8),
    .err(err8), .r_mod_m(r8), .r2_mod_m(r28), .m_prime(mp8));
  montgomery_precompute #(.WORD_WIDTH(32)) d32 (
    .clk(clk), .reset(reset), .start(s32), .m(m32), .busy(busy32), .done(done32),
    .err(err32), .r_mod_m(r32), .r2_mod_m(r232), .m_prime(mp32));
  function automatic logic [127:0] pmod(input int e, input logic [127:0] mm);
    return mm == 0 ? 128'd0 : (128'd1 << e) % mm;
  endfunction
  task automatic run8(input logic [7:0] v, output int lat);
    lat = -1;
    s8 = 1'b1;
    m8 = v;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (busy8) break;
    end
    s8 = 1'b0;
    if (busy8)
      for (int i = 1; i < 200; i++) begin
        @(posedge clk); @(negedge clk);
        if (done8) begin lat = i; break; end
      end
  endtask
  task automatic run32(input logic [31:0] v, output int lat);
    lat = -1;
    s32 = 1'b1;
    m32 = v;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (busy32) break;
    end
    s32 = 1'b0;
    if (busy32)
      for (int i = 1; i < 200; i++) begin
        @(posedge clk); @(negedge clk);
        if (done32) begin lat = i; break; end
      end
  endtask
  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    nt++; if ({busy8, done8, err8, r8, r28, mp8} !== '0) $display("FAIL reset8 got %h want 0", {busy8, done8, err8, r8, r28, mp8}); else np++;
    nt++; if ({busy32, done32, err32, r32, r232, mp32} !== '0) $display("FAIL reset32 got %h want 0", {busy32, done32, err32, r32, r232, mp32}); else np++;
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_basic;
    int lat;
    run8(8'd13, lat);
    nt++; if (lat !== 16) $display("FAIL basic_lat got %0d want 16", lat); else np++;
    nt++; if (r8 !== 8'(pmod(8, 13))) $display("FAIL basic_r got %0d want %0d", r8, pmod(8, 13)); else np++;
    nt++; if (r28 !== 8'(pmod(16, 13))) $display("FAIL basic_r2 got %0d want %0d", r28, pmod(16, 13)); else np++;
    nt++; if (err8 !== 1'b0) $display("FAIL basic_err got %b want 0", err8); else np++;
    nt++; if (mp8 !== (MP ? 8'd59 : 8'd0)) $display("FAIL basic_mp got %0d want %0d", mp8, MP ? 59 : 0); else np++;
    nt++; if (busy8 !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", busy8); else np++;
    @(negedge clk);
    nt++; if (done8 !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done8); else np++;
    nt++; if (r8 !== 8'd9) $display("FAIL basic_hold got %0d want 9", r8); else np++;
  endtask
  task automatic test_boundary;
    int lat;
    run8(8'd255, lat);
    nt++; if ({r8, r28} !== {8'd1, 8'd1}) $display("FAIL m255_r got %0d/%0d want 1/1", r8, r28); else np++;
    nt++; if (mp8 !== (MP ? 8'd1 : 8'd0)) $display("FAIL m255_mp got %0d want %0d", mp8, MP ? 1 : 0); else np++;
    run8(8'd1, lat);
    nt++; if (lat !== 16) $display("FAIL m1_lat got %0d want 16", lat); else np++;
    nt++; if ({r8, r28} !== 16'd0) $display("FAIL m1_r got %0d/%0d want 0/0", r8, r28); else np++;
    nt++; if (mp8 !== (MP ? 8'd255 : 8'd0)) $display("FAIL m1_mp got %0d want %0d", mp8, MP ? 255 : 0); else np++;
  endtask
  task automatic test_ignore;
    int lat, extra;
    lat = -1;
    extra = 0;
    s8 = 1'b1;
    m8 = 8'd13;
    for (int i = 0; i < 4 && !busy8; i++) begin @(posedge clk); @(negedge clk); end
    s8 = 1'b0;
    for (int i = 1; i < 200; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 3) begin s8 = 1'b1; m8 = 8'd7; end
      if (i == 5) s8 = 1'b0;
      if (done8) begin lat = i; break; end
    end
    nt++; if (lat !== 16) $display("FAIL ignore_lat got %0d want 16", lat); else np++;
    nt++; if ({r8, r28} !== {8'd9, 8'd3}) $display("FAIL ignore_r got %0d/%0d want 9/3", r8, r28); else np++;
    repeat (40) begin @(posedge clk); @(negedge clk); if (done8) extra++; end
    nt++; if (extra !== 0) $display("FAIL ignore_extra_done got %0d want 0", extra); else np++;
  endtask
  task automatic test_even;
    int lat;
    run8(8'd12, lat);
    nt++; if (lat !== 1) $display("FAIL m12_lat got %0d want 1", lat); else np++;
    nt++; if ({err8, r8, r28, mp8} !== {1'b1, 24'd0}) $display("FAIL m12_out got %b/%0d/%0d/%0d want 1/0/0/0", err8, r8, r28, mp8); else np++;
    run8(8'd0, lat);
    nt++; if (lat !== 1) $display("FAIL m0_lat got %0d want 1", lat); else np++;
    nt++; if ({err8, r8, r28} !== {1'b1, 16'd0}) $display("FAIL m0_out got %b/%0d/%0d want 1/0/0", err8, r8, r28); else np++;
    run8(8'd251, lat);
    nt++; if (err8 !== 1'b0) $display("FAIL m251_err got %b want 0", err8); else np++;
    nt++; if ({r8, r28} !== {8'(pmod(8, 251)), 8'(pmod(16, 251))}) $display("FAIL m251_r got %0d/%0d want 5/25", r8, r28); else np++;
  endtask
  task automatic test_midreset;
    int lat, seen;
    seen = 0;
    s8 = 1'b1;
    m8 = 8'd13;
    for (int i = 0; i < 4 && !busy8; i++) begin @(posedge clk); @(negedge clk); end
    s8 = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    nt++; if ({busy8, done8, err8, r8, r28, mp8} !== '0) $display("FAIL midreset_out got %h want 0", {busy8, done8, err8, r8, r28, mp8}); else np++;
    @(negedge clk) reset = 1'b0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (done8 || busy8) seen++; end
    nt++; if (seen !== 0) $display("FAIL midreset_no_done got %0d want 0", seen); else np++;
    run8(8'd13, lat);
    nt++; if ({lat[7:0], r8, r28} !== {8'd16, 8'd9, 8'd3}) $display("FAIL midreset_rerun got %0d %0d/%0d want 16 9/3", lat, r8, r28); else np++;
  endtask
  task automatic test_random;
    int lat;
    logic [31:0] v;
    bit ok_mp;
    for (int k = 0; k < 100; k++) begin
      v = $urandom | 32'd1;
      run32(v, lat);
      ok_mp = MP ? (32'(v * mp32 + 32'd1) == 32'd0) : (mp32 == 32'd0);
      nt++; if (lat !== 64) $display("FAIL rnd_lat m=%h got %0d want 64", v, lat); else np++;
      nt++; if (r32 !== 32'(pmod(32, v))) $display("FAIL rnd_r m=%h got %h want %h", v, r32, pmod(32, v)); else np++;
      nt++; if (r232 !== 32'(pmod(64, v))) $display("FAIL rnd_r2 m=%h got %h want %h", v, r232, pmod(64, v)); else np++;
      nt++; if (err32 !== 1'b0) $display("FAIL rnd_err m=%h got %b want 0", v, err32); else np++;
      nt++; if (!ok_mp) $display("FAIL rnd_mp m=%h got %h want inverse relation", v, mp32); else np++;
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_boundary;
    test_ignore;
    test_even;
    test_midreset;
    test_random;
    $display("%0d/%0d checks passed", np, nt);
    $finish;
  end
endmodule
